// File: rtl/bus_err_tracker.sv
`default_nettype none
// ============================================================================
// Module  : bus_err_tracker
// Brief   : Per-channel outstanding-address tracking with an error log FIFO,
//           saturating error/drop counters and a usage-threshold interrupt.
// Revision: 1.0
// ============================================================================
module bus_err_tracker #(
    parameter int unsigned AddrWidth       = 48,
    parameter int unsigned ErrBits         = 3,
    parameter int unsigned NumChannels     = 2,
    parameter int unsigned NumOutstanding  = 4,
    parameter int unsigned NumStoredErrors = 8,
    parameter bit          DropOldest      = 1'b0,
    parameter int unsigned CntWidth        = 16
) (
    input  logic                                                      clk_i,
    input  logic                                                      rst_ni,
    input  logic                                                      testmode_i,
    input  logic                                                      clear_i,
    input  logic [NumChannels-1:0]                                    req_hs_valid_i,
    input  logic [AddrWidth-1:0]                                      req_addr_i,
    input  logic [NumChannels-1:0]                                    rsp_hs_valid_i,
    input  logic [NumChannels-1:0]                                    rsp_burst_last_i,
    input  logic [ErrBits-1:0]                                        rsp_err_i,
    input  logic [ErrBits-1:0]                                        err_mask_i,
    input  logic [$clog2(NumStoredErrors+1)-1:0]                      irq_thresh_i,
    output logic                                                      err_valid_o,
    input  logic                                                      err_ready_i,
    output logic [AddrWidth-1:0]                                      err_addr_o,
    output logic [ErrBits-1:0]                                        err_code_o,
    output logic [((NumChannels > 1) ? $clog2(NumChannels) : 1)-1:0]  err_chan_o,
    output logic                                                      err_unexp_o,
    output logic [CntWidth-1:0]                                       err_count_o,
    output logic [CntWidth-1:0]                                       drop_count_o,
    output logic                                                      track_lost_o,
    output logic                                                      err_irq_o
);

    localparam int unsigned C_CHAN_W = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int unsigned C_APTR_W = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam int unsigned C_ACNT_W = $clog2(NumOutstanding + 1);
    localparam int unsigned C_LPTR_W = (NumStoredErrors > 1) ? $clog2(NumStoredErrors) : 1;
    localparam int unsigned C_LCNT_W = $clog2(NumStoredErrors + 1);
    localparam int unsigned C_ENT_W  = AddrWidth + ErrBits + C_CHAN_W + 1;

    logic                    w_unused_testmode;
    logic [AddrWidth-1:0]    w_head [NumChannels];
    logic [NumChannels-1:0]  w_has;
    logic [NumChannels-1:0]  w_lost;

    assign w_unused_testmode = testmode_i;

    // ------------------------------------------------------------------------
    // Per-channel outstanding address FIFOs
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < NumChannels; gi++) begin : g_chan
        logic [AddrWidth-1:0] r_mem [NumOutstanding];
        logic [C_APTR_W-1:0]  r_rd;
        logic [C_APTR_W-1:0]  r_wr;
        logic [C_ACNT_W-1:0]  r_cnt;
        logic                 w_empty;
        logic                 w_full;
        logic                 w_pop;
        logic                 w_push;

        assign w_empty    = (r_cnt == '0);
        assign w_full     = (r_cnt == C_ACNT_W'(NumOutstanding));
        assign w_pop      = rsp_hs_valid_i[gi] & rsp_burst_last_i[gi] & ~w_empty;
        assign w_push     = req_hs_valid_i[gi] & (~w_full | w_pop);
        assign w_lost[gi] = req_hs_valid_i[gi] & w_full & ~w_pop;
        assign w_head[gi] = r_mem[r_rd];
        assign w_has[gi]  = ~w_empty;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_rd  <= '0;
                r_wr  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_wr <= (r_wr == C_APTR_W'(NumOutstanding - 1)) ? '0 : r_wr + 1'b1;
                end
                if (w_pop) begin
                    r_rd <= (r_rd == C_APTR_W'(NumOutstanding - 1)) ? '0 : r_rd + 1'b1;
                end
                r_cnt <= r_cnt + C_ACNT_W'(w_push) - C_ACNT_W'(w_pop);
            end
        end

        always_ff @(posedge clk_i) begin
            if (w_push) begin
                r_mem[r_wr] <= req_addr_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Error detection on the (one-hot) responding channel
    // ------------------------------------------------------------------------
    logic [C_CHAN_W-1:0]  w_sel_chan;
    logic [AddrWidth-1:0] w_sel_addr;
    logic                 w_sel_has;
    logic                 w_err;
    logic [C_ENT_W-1:0]   w_entry;

    always_comb begin
        w_sel_chan = '0;
        w_sel_addr = '0;
        w_sel_has  = 1'b0;
        for (int i = 0; i < NumChannels; i++) begin
            if (rsp_hs_valid_i[i]) begin
                w_sel_chan = C_CHAN_W'(i);
                w_sel_addr = w_head[i];
                w_sel_has  = w_has[i];
            end
        end
    end

    assign w_err   = (|rsp_hs_valid_i) & (|(rsp_err_i & ~err_mask_i));
    // An error with nothing outstanding is logged as unexpected at address 0
    assign w_entry = {(w_sel_has ? w_sel_addr : {AddrWidth{1'b0}}),
                      rsp_err_i, w_sel_chan, ~w_sel_has};

    // ------------------------------------------------------------------------
    // Error log FIFO
    // ------------------------------------------------------------------------
    logic [C_ENT_W-1:0]  r_lmem [NumStoredErrors];
    logic [C_LPTR_W-1:0] r_lrd;
    logic [C_LPTR_W-1:0] r_lwr;
    logic [C_LCNT_W-1:0] r_lcnt;
    logic                w_lfull;
    logic                w_rd_pop;
    logic                w_new;
    logic                w_drop;
    logic                w_evict;
    logic                w_lpush;
    logic                w_lpop;
    logic [C_ENT_W-1:0]  w_lhead;

    assign err_valid_o = (r_lcnt != '0);
    assign w_lfull     = (r_lcnt == C_LCNT_W'(NumStoredErrors));
    assign w_rd_pop    = err_valid_o & err_ready_i;
    assign w_new       = w_err & ~clear_i;
    assign w_drop      = w_new & w_lfull & ~w_rd_pop;
    assign w_evict     = w_drop & DropOldest;
    assign w_lpush     = w_new & (~w_drop | DropOldest);
    assign w_lpop      = w_rd_pop | w_evict;
    assign w_lhead     = r_lmem[r_lrd];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lrd  <= '0;
            r_lwr  <= '0;
            r_lcnt <= '0;
        end else if (clear_i) begin
            r_lrd  <= '0;
            r_lwr  <= '0;
            r_lcnt <= '0;
        end else begin
            if (w_lpush) begin
                r_lwr <= (r_lwr == C_LPTR_W'(NumStoredErrors - 1)) ? '0 : r_lwr + 1'b1;
            end
            if (w_lpop) begin
                r_lrd <= (r_lrd == C_LPTR_W'(NumStoredErrors - 1)) ? '0 : r_lrd + 1'b1;
            end
            r_lcnt <= r_lcnt + C_LCNT_W'(w_lpush) - C_LCNT_W'(w_lpop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_lpush) begin
            r_lmem[r_lwr] <= w_entry;
        end
    end

    // Gating keeps the read port at zero whenever the log is empty
    assign {err_addr_o, err_code_o, err_chan_o, err_unexp_o} =
        err_valid_o ? w_lhead : {C_ENT_W{1'b0}};

    // ------------------------------------------------------------------------
    // Counters, sticky loss flag and interrupt
    // ------------------------------------------------------------------------
    logic [CntWidth-1:0] r_err_cnt;
    logic [CntWidth-1:0] r_drop_cnt;
    logic                r_lost;
    logic                r_irq;
    logic [C_LCNT_W-1:0] w_thr;

    assign w_thr = (irq_thresh_i == '0) ? C_LCNT_W'(1) : irq_thresh_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_cnt  <= '0;
            r_drop_cnt <= '0;
            r_lost     <= 1'b0;
            r_irq      <= 1'b0;
        end else if (clear_i) begin
            r_err_cnt  <= '0;
            r_drop_cnt <= '0;
            r_lost     <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            r_lost <= r_lost | (|w_lost);
            r_irq  <= (r_lcnt >= w_thr);
        end
    end

    assign err_count_o  = r_err_cnt;
    assign drop_count_o = r_drop_cnt;
    assign track_lost_o = r_lost;
    assign err_irq_o    = r_irq;

`ifndef SYNTHESIS
    a_req_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(req_hs_valid_i));
    a_rsp_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(rsp_hs_valid_i));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_err_tracker.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_err_tracker
// Brief   : Randomized and directed bench for bus_err_tracker (both log
//           overflow policies side by side) against a queue-based model.
// Revision: 1.0
// ============================================================================
module tb_bus_err_tracker;

    localparam int DEPTH = 8;
    localparam int NOUT  = 4;
    localparam int CMAX  = 65535;

    typedef struct packed {
        logic [47:0] addr;
        logic [2:0]  code;
        logic        chan;
        logic        unexp;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        testmode;
    logic        clear;
    logic        ready;
    logic [1:0]  req_v;
    logic [1:0]  rsp_v;
    logic [1:0]  last;
    logic [47:0] addr;
    logic [2:0]  err_in;
    logic [2:0]  mask;
    logic [3:0]  thresh;

    logic [1:0]  o_valid;
    logic [1:0]  o_chan;
    logic [1:0]  o_unexp;
    logic [1:0]  o_lost;
    logic [1:0]  o_irq;
    logic [47:0] o_addr    [2];
    logic [2:0]  o_code    [2];
    logic [15:0] o_errcnt  [2];
    logic [15:0] o_dropcnt [2];

    always #5 clk = ~clk;

    bus_err_tracker #(.DropOldest(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .testmode_i(testmode), .clear_i(clear),
        .req_hs_valid_i(req_v), .req_addr_i(addr),
        .rsp_hs_valid_i(rsp_v), .rsp_burst_last_i(last), .rsp_err_i(err_in),
        .err_mask_i(mask), .irq_thresh_i(thresh),
        .err_valid_o(o_valid[0]), .err_ready_i(ready), .err_addr_o(o_addr[0]),
        .err_code_o(o_code[0]), .err_chan_o(o_chan[0]), .err_unexp_o(o_unexp[0]),
        .err_count_o(o_errcnt[0]), .drop_count_o(o_dropcnt[0]),
        .track_lost_o(o_lost[0]), .err_irq_o(o_irq[0])
    );

    bus_err_tracker #(.DropOldest(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .testmode_i(testmode), .clear_i(clear),
        .req_hs_valid_i(req_v), .req_addr_i(addr),
        .rsp_hs_valid_i(rsp_v), .rsp_burst_last_i(last), .rsp_err_i(err_in),
        .err_mask_i(mask), .irq_thresh_i(thresh),
        .err_valid_o(o_valid[1]), .err_ready_i(ready), .err_addr_o(o_addr[1]),
        .err_code_o(o_code[1]), .err_chan_o(o_chan[1]), .err_unexp_o(o_unexp[1]),
        .err_count_o(o_errcnt[1]), .drop_count_o(o_dropcnt[1]),
        .track_lost_o(o_lost[1]), .err_irq_o(o_irq[1])
    );

    // Reference model state; index d selects the overflow policy (1 = evict oldest)
    logic [47:0] m_aq  [2][$];
    ent_t        m_log [2][$];
    int          m_err_cnt;
    int          m_drop [2];
    bit          m_lost;
    bit          m_irq  [2];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) m_aq[c].delete();
        for (int d = 0; d < 2; d++) begin
            m_log[d].delete();
            m_drop[d] = 0;
            m_irq[d]  = 1'b0;
        end
        m_err_cnt = 0;
        m_lost    = 1'b0;
    endtask

    // Applies one clock edge worth of behaviour using the inputs held before the edge
    task automatic model_update();
        int   ch;
        int   thr;
        bit   err;
        bit   lost_ev;
        ent_t e;
        thr = (thresh == 0) ? 1 : int'(thresh);
        for (int d = 0; d < 2; d++)
            m_irq[d] = clear ? 1'b0 : (m_log[d].size() >= thr);
        ch  = rsp_v[1] ? 1 : 0;
        err = (rsp_v != 2'b00) && ((err_in & ~mask) != 3'b000);
        e.addr  = (m_aq[ch].size() > 0) ? m_aq[ch][0] : 48'h0;
        e.unexp = (m_aq[ch].size() == 0);
        e.code  = err_in;
        e.chan  = ch[0];
        for (int d = 0; d < 2; d++) begin
            if (clear) begin
                m_log[d].delete();
                m_drop[d] = 0;
            end else begin
                if (m_log[d].size() != 0 && ready) void'(m_log[d].pop_front());
                if (err) begin
                    if (m_log[d].size() < DEPTH) m_log[d].push_back(e);
                    else begin
                        if (m_drop[d] < CMAX) m_drop[d]++;
                        if (d == 1) begin
                            void'(m_log[d].pop_front());
                            m_log[d].push_back(e);
                        end
                    end
                end
            end
        end
        if (clear) m_err_cnt = 0;
        else if (err && m_err_cnt < CMAX) m_err_cnt++;
        lost_ev = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (rsp_v[c] && last[c] && m_aq[c].size() > 0) void'(m_aq[c].pop_front());
            if (req_v[c]) begin
                if (m_aq[c].size() < NOUT) m_aq[c].push_back(addr);
                else lost_ev = 1'b1;
            end
        end
        m_lost = clear ? 1'b0 : (m_lost | lost_ev);
    endtask

    task automatic compare_all();
        ent_t h;
        for (int d = 0; d < 2; d++) begin
            h = (m_log[d].size() != 0) ? m_log[d][0] : '0;
            check_val($sformatf("d%0d valid", d), o_valid[d], m_log[d].size() != 0);
            check_val($sformatf("d%0d addr", d), o_addr[d], h.addr);
            check_val($sformatf("d%0d code", d), o_code[d], h.code);
            check_val($sformatf("d%0d chan", d), o_chan[d], h.chan);
            check_val($sformatf("d%0d unexp", d), o_unexp[d], h.unexp);
            check_val($sformatf("d%0d err_count", d), o_errcnt[d], m_err_cnt);
            check_val($sformatf("d%0d drop_count", d), o_dropcnt[d], m_drop[d]);
            check_val($sformatf("d%0d track_lost", d), o_lost[d], m_lost);
            check_val($sformatf("d%0d irq", d), o_irq[d], m_irq[d]);
        end
    endtask

    task automatic idle_inputs();
        req_v  = 2'b00;
        rsp_v  = 2'b00;
        last   = 2'b00;
        err_in = 3'b000;
        addr   = 48'h0;
        clear  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic err_beat(input int ch, input logic [2:0] code, input bit is_last);
        rsp_v  = 2'b01 << ch;
        last   = is_last ? (2'b01 << ch) : 2'b00;
        err_in = code;
        step();
    endtask

    initial begin
        testmode = 1'b0;
        ready    = 1'b0;
        mask     = 3'b000;
        thresh   = 4'd8;
        do_reset();

        // Single expected error on ch0
        req_v = 2'b01; addr = 48'h1000; step();
        err_beat(0, 3'd2, 1'b1);
        check_val("basic valid", o_valid[0], 1);
        check_val("basic addr", o_addr[0], 48'h1000);
        check_val("basic code", o_code[0], 3'd2);
        check_val("basic unexp", o_unexp[0], 0);
        check_val("basic err_count", o_errcnt[0], 1);
        ready = 1'b1; step(); ready = 1'b0;

        // Mid-burst error on ch1, then a clean burst, then an unexpected error
        req_v = 2'b10; addr = 48'hA0; step();
        req_v = 2'b10; addr = 48'hB0; step();
        for (int b = 1; b <= 4; b++) err_beat(1, (b == 2) ? 3'd1 : 3'd0, b == 4);
        check_val("burst addr", o_addr[0], 48'hA0);
        check_val("burst chan", o_chan[0], 1);
        for (int b = 1; b <= 4; b++) err_beat(1, 3'd0, b == 4);
        check_val("burst err_count", o_errcnt[1], 2);
        err_beat(1, 3'd4, 1'b1);
        ready = 1'b1; repeat (3) step(); ready = 1'b0;

        // Error mask
        do_reset();
        mask = 3'b010;
        err_beat(0, 3'd2, 1'b1);
        check_val("mask hidden valid", o_valid[0], 0);
        check_val("mask hidden count", o_errcnt[0], 0);
        err_beat(0, 3'd3, 1'b1);
        check_val("mask code", o_code[0], 3'd3);
        check_val("mask unexp", o_unexp[0], 1);
        mask = 3'b000;

        // Log overflow under both policies
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            req_v = 2'b01; addr = 48'(i); step();
            err_beat(0, 3'd1, 1'b1);
        end
        check_val("ovf keep-first head", o_addr[0], 48'd1);
        check_val("ovf evict head", o_addr[1], 48'd3);
        check_val("ovf drop0", o_dropcnt[0], 2);
        check_val("ovf drop1", o_dropcnt[1], 2);
        check_val("ovf err_count", o_errcnt[1], 10);
        ready = 1'b1; repeat (9) step(); ready = 1'b0;

        // Interrupt threshold
        do_reset();
        thresh = 4'd3;
        err_beat(0, 3'd1, 1'b0);
        err_beat(0, 3'd1, 1'b0);
        step();
        check_val("irq below", o_irq[0], 0);
        err_beat(0, 3'd1, 1'b0);
        check_val("irq at entry", o_irq[0], 0);
        step();
        check_val("irq set", o_irq[0], 1);
        ready = 1'b1; step(); ready = 1'b0;
        step();
        check_val("irq after pop", o_irq[0], 0);

        // Tracking loss and clear
        do_reset();
        thresh = 4'd8;
        err_beat(1, 3'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            req_v = 2'b01; addr = 48'h100 + 48'(i); step();
        end
        check_val("lost set", o_lost[0], 1);
        clear = 1'b1; step();
        check_val("clear lost", o_lost[0], 0);
        check_val("clear count", o_errcnt[0], 0);
        check_val("clear valid", o_valid[0], 0);
        err_beat(0, 3'd5, 1'b1);
        check_val("after clear addr", o_addr[0], 48'h100);

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int rs;
            int ps;
            if (cyc == 1500) do_reset();
            rs     = $urandom_range(0, 3);
            ps     = $urandom_range(0, 3);
            req_v  = (rs < 2) ? (2'b01 << rs) : 2'b00;
            rsp_v  = (ps < 2) ? (2'b01 << ps) : 2'b00;
            last   = 2'($urandom);
            addr   = {16'($urandom), 32'($urandom)};
            err_in = ($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'b000;
            ready  = ($urandom_range(0, 2) == 0);
            clear  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 49) == 0) thresh = 4'($urandom_range(0, 8));
            if ($urandom_range(0, 49) == 0)
                mask = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_err_tracker.md
BUS_ERR_TRACKER -- requirements
Module: bus_err_tracker

Interface
REQ-001 SHALL have parameter AddrWidth, default 48, request address width.
REQ-002 SHALL have parameter ErrBits, default 3, response error code width.
REQ-003 SHALL have parameter NumChannels, default 2, one-hot response channels (>=1).
REQ-004 SHALL have parameter NumOutstanding, default 4, per-channel address FIFO depth.
REQ-005 SHALL have parameter NumStoredErrors, default 8, error log FIFO depth.
REQ-006 SHALL have parameter DropOldest, default 0, log overflow policy (1 = evict oldest, 0 = discard newest).
REQ-007 SHALL have parameter CntWidth, default 16, saturating counter width.
REQ-008 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset. One clock; reset asynchronous, active-low.
REQ-009 SHALL have ports: testmode_i in 1 test mode; clear_i in 1 synchronous clear.
REQ-010 SHALL have ports: req_hs_valid_i in NumChannels request handshake; req_addr_i in AddrWidth request address.
REQ-011 SHALL have ports: rsp_hs_valid_i in NumChannels response beat handshake; rsp_burst_last_i in NumChannels last beat; rsp_err_i in ErrBits error code.
REQ-012 SHALL have ports: err_mask_i in ErrBits code bits ignored for detection; irq_thresh_i in idx_width(NumStoredErrors+1) IRQ threshold.
REQ-013 SHALL have ports: err_valid_o out 1, err_ready_i in 1, err_addr_o out AddrWidth, err_code_o out ErrBits, err_chan_o out idx_width(NumChannels), err_unexp_o out 1 (log read port).
REQ-014 SHALL have ports: err_count_o out CntWidth, drop_count_o out CntWidth, track_lost_o out 1, err_irq_o out 1.

Function
REQ-015 SHALL keep one non-fall-through address FIFO per channel; push req_addr_i when req_hs_valid_i[i].
REQ-016 SHALL pop channel i address FIFO when rsp_hs_valid_i[i] & rsp_burst_last_i[i]; same-cycle push+pop on a non-empty FIFO both take effect.
REQ-017 Request into full address FIFO (no same-cycle pop) SHALL be dropped and set sticky track_lost_o.
REQ-018 Beat SHALL be an error when rsp_hs_valid_i[i] and (rsp_err_i & ~err_mask_i) != 0; any beat, not only last.
REQ-019 Error entry SHALL hold: head address of channel i FIFO, unmasked rsp_err_i, channel index i, unexp flag.
REQ-020 Error on a channel with empty address FIFO SHALL log addr 0 with unexp=1; that FIFO is not popped.
REQ-021 Logged entry SHALL appear on err_valid_o/err_* the cycle after the response beat (latency 1).
REQ-022 err_valid_o SHALL equal log non-empty; entry popped on err_valid_o & err_ready_i; err_* stable while valid and not ready.
REQ-023 Log full, new error, reader pop same cycle: SHALL accept both, no drop.
REQ-024 Log full, new error, no reader pop: DropOldest=1 evicts head and pushes new; DropOldest=0 discards new; either case drop_count_o +1.
REQ-025 err_count_o SHALL increment per detected error, including dropped ones; both counters saturate at all-ones.
REQ-026 err_irq_o SHALL be registered: 1 when log usage >= max(irq_thresh_i,1), updated one cycle after usage changes.
REQ-027 clear_i SHALL zero counters, flush log, clear track_lost_o and err_irq_o next cycle; address FIFOs unaffected; an error in the clear cycle is discarded.
REQ-028 Non-one-hot req_hs_valid_i or rsp_hs_valid_i SHALL trigger a simulation assertion; RTL behaviour then unspecified.

Reset
REQ-029 On rst_ni low SHALL asynchronously empty all FIFOs and zero all outputs: err_valid_o=0, err_* =0, counters=0, track_lost_o=0, err_irq_o=0.
REQ-030 Reset mid-burst SHALL discard outstanding addresses; first response after reset with error logs unexp=1.

Verification
REQ-031 Ch0 req 0x1000, ch0 last beat err=2, mask=0 -> next cycle err_valid_o=1, addr 0x1000, code 2, chan 0, unexp 0, err_count 1.
REQ-032 Ch1 reqs 0xA0,0xB0; 4-beat burst err on beat 2 (not last), second burst OK -> one entry addr 0xA0; FIFO head then 0xB0.
REQ-033 mask=3'b010, err=2 -> no entry, err_count 0; err=3 -> entry code 3.
REQ-034 Depth 8, err_ready_i=0, 10 errors -> DropOldest=0: entries 1-8 kept, drop_count 2; DropOldest=1: entries 3-10 kept, drop_count 2; err_count 10.
REQ-035 irq_thresh_i=3: 2 errors -> err_irq_o=0; third -> err_irq_o=1 one cycle after entry visible; pop one -> 0.
REQ-036 5 ch0 reqs without responses (depth 4) -> track_lost_o=1; clear_i -> track_lost_o=0, counters 0, err_valid_o=0.
